// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: requester beat bus and response slot handshake
// for the shared 64-bit adder arbiter.
interface adder_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [64*NREQ-1:0]   req_a;
    logic [64*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic [NREQ-1:0]      req_last;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [63:0]          rsp_sum;
    logic                 rsp_cout;
    logic                 rsp_last;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
    );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin, burst-locking arbiter sharing one
// hybrid BK4/KS2 64-bit prefix adder, with a registered response slot.
module hc_64_bk4_ks2 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [63:0] g;
    logic [63:0] p;
    logic [15:0] grp_g;
    logic [15:0] grp_p;
    logic [15:0] ks_g [5];
    logic [15:0] ks_p [5];
    logic [15:0] gc;
    logic        cc;

    assign g = a & b;
    assign p = a ^ b;

    // radix-4 group generate/propagate (Brent-Kung leaf level)
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int j = 0; j < 16; j++) begin
            grp_g[j] = g[4*j+3] | (p[4*j+3] & (g[4*j+2] | (p[4*j+2] &
                       (g[4*j+1] | (p[4*j+1] & g[4*j])))));
            grp_p[j] = &p[4*j +: 4];
        end
    end

    // radix-2 Kogge-Stone prefix tree over the 16 groups
    always_comb begin
        ks_g[0] = grp_g;
        ks_p[0] = grp_p;
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 16; j++) begin
                if (j >= (1 << l)) begin
                    ks_g[l+1][j] = ks_g[l][j] |
                                   (ks_p[l][j] & ks_g[l][j-(1<<l)]);
                    ks_p[l+1][j] = ks_p[l][j] & ks_p[l][j-(1<<l)];
                end else begin
                    ks_g[l+1][j] = ks_g[l][j];
                    ks_p[l+1][j] = ks_p[l][j];
                end
            end
        end
    end

    // group carry-ins, then ripple inside each 4-bit group
    always_comb begin
        gc    = '0;
        gc[0] = cin;
        for (int j = 1; j < 16; j++) begin
            gc[j] = ks_g[4][j-1] | (ks_p[4][j-1] & cin);
        end
        sum = '0;
        cc  = 1'b0;
        for (int j = 0; j < 16; j++) begin
            cc = gc[j];
            for (int i = 0; i < 4; i++) begin
                sum[4*j+i] = p[4*j+i] ^ cc;
                cc = g[4*j+i] | (p[4*j+i] & cc);
            end
        end
        cout = ks_g[4][15] | (ks_p[4][15] & cin);
    end
endmodule

module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    adder_share_arb_if.slave bus,
    output logic             busy
);
    typedef enum logic {IDLE, LOCK} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           carry_q, carry_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [63:0]    rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_last_q, rsp_last_d;

    logic [IDW-1:0] gnt_idx, hi_idx, lo_idx;
    logic           gnt_any, hi_any, lo_any, own_valid;
    logic           slot_free, accept;
    logic [63:0]    add_a, add_b, add_sum;
    logic           add_cin, add_cout, sel_cin, sel_last;

    // grant: locked owner, else first valid at or above rr_ptr, else wrap
    always_comb begin
        hi_any    = 1'b0;
        hi_idx    = '0;
        lo_any    = 1'b0;
        lo_idx    = '0;
        own_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                lo_any = 1'b1;
                lo_idx = IDW'(k);
                if (IDW'(k) >= rr_ptr_q) begin
                    hi_any = 1'b1;
                    hi_idx = IDW'(k);
                end
            end
            if (owner_q == IDW'(k)) begin
                own_valid = bus.req_valid[k];
            end
        end
        if (state_q == LOCK) begin
            gnt_any = own_valid;
            gnt_idx = owner_q;
        end else begin
            gnt_any = lo_any;
            gnt_idx = hi_any ? hi_idx : lo_idx;
        end
    end

    assign slot_free = !rsp_valid_q || bus.rsp_ready;
    assign accept    = gnt_any && slot_free;

    // operand mux and one-hot ready for the granted requester
    always_comb begin
        add_a         = '0;
        add_b         = '0;
        sel_cin       = 1'b0;
        sel_last      = 1'b0;
        bus.req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                add_a            = bus.req_a[64*k +: 64];
                add_b            = bus.req_b[64*k +: 64];
                sel_cin          = bus.req_cin[k];
                sel_last         = bus.req_last[k];
                bus.req_ready[k] = accept;
            end
        end
    end

    // mid-burst beats take the chained carry, not the requester's cin
    assign add_cin = (state_q == LOCK) ? carry_q : sel_cin;

    hc_64_bk4_ks2 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // next state: burst lock, pointer advance, response slot load/drain
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        rsp_last_d  = rsp_last_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
            rsp_id_d    = gnt_idx;
            rsp_last_d  = sel_last;
            carry_d     = add_cout;
            if (sel_last) begin
                state_d  = IDLE;
                rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0
                                                       : gnt_idx + IDW'(1);
            end else begin
                state_d = LOCK;
                owner_d = gnt_idx;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_last  = rsp_last_q;
    assign busy          = (state_q == LOCK) || rsp_valid_q;
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one instance of the 64-bit hybrid BK4/KS2 prefix adder (HC_64_BK4_KS2) among NREQ requesters.
- Arbitration is round-robin with burst locking, so a requester can issue multi-beat (multi-precision) additions. Between beats of a burst, the carry-out of one beat is chained into the carry-in of the next.
- The adder result is registered into a single response slot that supports valid/ready backpressure.
- Sits between requester clients (multi-precision ALU, address generators) and the shared adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester beat valid.
- req_ready  output  NREQ  per-requester beat accept; at most one bit high in any cycle.
- req_a  input  64*NREQ  operand A; slice [64*k+63:64*k] belongs to requester k.
- req_b  input  64*NREQ  operand B, same slicing as req_a.
- req_cin  input  NREQ  carry-in; used only on the first beat of a burst.
- req_last  input  NREQ  marks the final beat of a burst.
- rsp_valid  output  1  response slot full.
- rsp_ready  input  1  downstream accepts the response.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_sum  output  64  registered sum.
- rsp_cout  output  1  registered carry-out.
- rsp_last  output  1  copy of req_last for this beat.
- busy  output  1  high when the FSM is in LOCK or rsp_valid=1.

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_last=0, req_ready=0, busy=0. Internal state: FSM=IDLE, rr_ptr=0, carry_q=0.
- Slot availability: slot_free = !rsp_valid | rsp_ready.
- Acceptance: a beat is accepted when req_valid[g] & req_ready[g] for the granted requester g.
  - req_ready[g] = slot_free & grant[g].
  - req_ready is combinational from req_valid, FSM state and slot_free.
- FSM IDLE:
  - grant = the first requester with req_valid set, searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, … NREQ-1, 0, …).
  - On accept with req_last=1: stay in IDLE, rr_ptr <= g+1 mod NREQ.
  - On accept with req_last=0: go to LOCK, owner <= g.
- FSM LOCK:
  - Only the owner can be granted. Other requesters stall even if the owner's req_valid is low; there is no timeout.
  - On an owner accept with req_last=1: go to IDLE, rr_ptr <= owner+1 mod NREQ.
- Adder carry-in: req_cin[g] in IDLE; carry_q in LOCK.
- On every accept:
  - carry_q <= adder cout.
  - rsp_sum, rsp_cout, rsp_id, rsp_last are loaded from the adder outputs and the beat.
  - rsp_valid <= 1.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 beat per cycle while rsp_ready=1.
- Simultaneous drain and accept: when rsp_valid & rsp_ready and a new beat is accepted in the same cycle, the slot is overwritten and rsp_valid stays 1 with no bubble.
- Drain with no accept: rsp_valid <= 0; payload registers hold their values.
- Full slot: when rsp_valid & !rsp_ready, all req_ready=0 and the payload is held stable. The FSM, owner, carry_q and rr_ptr do not change.
- Arithmetic: rsp_sum = (A + B + cin) mod 2^64, and rsp_cout = bit 64 of that sum. The result must match a behavioural adder for all inputs.
- Reset asserted mid-burst: the burst is abandoned and carry_q cleared. The next beat from any requester is treated as the first beat of a new burst.
- Inputs of a requester are ignored (don't-care) when it is not granted.

Test Plan:
- Single beat from requester 2: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, last=1 -> one cycle later rsp_valid=1, rsp_sum=0, rsp_cout=1, rsp_id=2; rr_ptr then points to requester 3.
- 128-bit burst from requester 1:
  - beat0: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, last=0 -> rsp_sum=0, cout=1.
  - beat1: a=5, b=6, cin ignored (drive 0), last=1 -> rsp_sum=12 (carry chained).
  - requesters 0/3 are held valid throughout and get req_ready=0 until beat1 is accepted.
- Round-robin fairness: all 4 requesters issue continuous single-beat requests with rsp_ready=1 -> grant order 0,1,2,3,0,… and exactly one response per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with a slot full and requester 0 valid -> req_ready=0, rsp_* stable. When rsp_ready rises, the drain and the next accept happen in the same cycle with no bubble.
- Reset mid-burst: requester 3 sends beat0 producing cout=1, then rst pulses asynchronously (not clock-aligned) -> all outputs are 0 immediately. The next beat, a=1, b=1, cin=0 from requester 0, gives rsp_sum=2 (no stale carry).
- Random regression: 10k beats with random valid/last/rsp_ready -> every response matches the reference model of 64-bit chained addition, and each burst keeps its beats contiguous and in order.
